// File: rtl/eth_traffic_csr_mp.sv
// Ethernet traffic CSR block: AFU DFH/ID registers, scratch, link status and an
// indirect request engine that forwards host commands to per-port traffic controllers.
module eth_traffic_csr_mp #(
  parameter int unsigned NUM_PORTS   = 8,
  parameter int unsigned PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0,
  parameter logic [23:0] NEXT_DFH    = 24'h0,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 csr_wr,
  input  logic                 csr_rd,
  input  logic [15:0]          csr_addr,
  input  logic [63:0]          csr_wdata,
  output logic [63:0]          csr_rdata,
  output logic                 csr_rvalid,
  output logic                 tc_rd,
  output logic                 tc_wr,
  output logic [15:0]          tc_addr,
  output logic [31:0]          tc_wdata,
  output logic [PORT_W-1:0]    tc_port,
  input  logic                 tc_ack,
  input  logic [31:0]          tc_rdata,
  output logic                 init_start,
  input  logic                 init_done,
  output logic                 swap_en,
  input  logic [NUM_PORTS-1:0] link_up
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [15:0] ADDR_DFH     = 16'h0000;
  localparam logic [15:0] ADDR_ID_L    = 16'h0008;
  localparam logic [15:0] ADDR_ID_H    = 16'h0010;
  localparam logic [15:0] ADDR_INIT    = 16'h0028;
  localparam logic [15:0] ADDR_CMD     = 16'h0030;
  localparam logic [15:0] ADDR_DATA    = 16'h0038;
  localparam logic [15:0] ADDR_PORT    = 16'h0040;
  localparam logic [15:0] ADDR_SCRATCH = 16'h0048;
  localparam logic [15:0] ADDR_SWAP    = 16'h0050;
  localparam logic [15:0] ADDR_LINK    = 16'h0058;

  localparam logic [63:0] DFH_VAL = {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, NEXT_DFH, 4'h1, 12'h0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tc_rd_q, tc_rd_d;
  logic                  tc_wr_q, tc_wr_d;
  logic [15:0]           tc_addr_q, tc_addr_d;
  logic [31:0]           tc_wdata_q, tc_wdata_d;
  logic [PORT_W-1:0]     tc_port_q, tc_port_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [PORT_W-1:0]     port_q, port_d;
  logic [63:0]           scratch_q, scratch_d;
  logic                  swap_q, swap_d;
  logic                  init_start_q, init_start_d;
  logic                  ack_trans_q, ack_trans_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [NUM_PORTS-1:0]  link_q, link_d;
  logic [NUM_PORTS-1:0]  sticky_q, sticky_d;
  logic [63:0]           csr_rdata_q, csr_rdata_d;
  logic                  csr_rvalid_q, csr_rvalid_d;

  logic                  busy;
  logic [63:0]           rd_mux;
  logic                  wr_cmd, wr_data, wr_port, wr_init, wr_scratch, wr_swap, wr_link;
  logic [NUM_PORTS-1:0]  link_clr;

  assign busy = (state_q != ST_IDLE);

  // Host write strobes per register
  always_comb begin
    wr_cmd     = csr_wr && (csr_addr == ADDR_CMD);
    wr_data    = csr_wr && (csr_addr == ADDR_DATA);
    wr_port    = csr_wr && (csr_addr == ADDR_PORT);
    wr_init    = csr_wr && (csr_addr == ADDR_INIT);
    wr_scratch = csr_wr && (csr_addr == ADDR_SCRATCH);
    wr_swap    = csr_wr && (csr_addr == ADDR_SWAP);
    wr_link    = csr_wr && (csr_addr == ADDR_LINK);
    link_clr   = wr_link ? csr_wdata[32 +: NUM_PORTS] : '0;
  end

  // Read mux built from current (pre-write) register state
  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      ADDR_DFH:     rd_mux = DFH_VAL;
      ADDR_ID_L:    rd_mux = AFU_ID_L;
      ADDR_ID_H:    rd_mux = AFU_ID_H;
      ADDR_INIT:    rd_mux = {62'h0, init_done, 1'b0};
      ADDR_CMD:     rd_mux = {16'h0, tc_addr_q, 27'h0, timeout_err_q, busy, ack_trans_q, 2'b00};
      ADDR_DATA:    rd_mux = {wr_data_q, rd_data_q};
      ADDR_PORT:    rd_mux = 64'(port_q);
      ADDR_SCRATCH: rd_mux = scratch_q;
      ADDR_SWAP:    rd_mux = {63'h0, swap_q};
      ADDR_LINK:    rd_mux = {32'(sticky_q), 32'(link_q)};
      default:      rd_mux = '0;
    endcase
  end

  // Next-state for CSRs and the indirect request engine
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tc_rd_d       = tc_rd_q;
    tc_wr_d       = tc_wr_q;
    tc_addr_d     = tc_addr_q;
    tc_wdata_d    = tc_wdata_q;
    tc_port_d     = tc_port_q;
    rd_data_d     = rd_data_q;
    wr_data_d     = wr_data_q;
    port_d        = port_q;
    scratch_d     = scratch_q;
    swap_d        = swap_q;
    ack_trans_d   = ack_trans_q;
    timeout_err_d = timeout_err_q;
    init_start_d  = wr_init && csr_wdata[0];
    csr_rvalid_d  = csr_rd;
    csr_rdata_d   = csr_rd ? rd_mux : csr_rdata_q;
    link_d        = link_up;
    // Set beats clear: a fall on the same edge as a W1C keeps the flag
    sticky_d      = (sticky_q & ~link_clr) | (link_q & ~link_up);

    if (wr_scratch) scratch_d = csr_wdata;
    if (wr_swap)    swap_d    = csr_wdata[0];
    if (wr_data)    wr_data_d = csr_wdata[63:32];
    if (wr_port && (csr_wdata < 64'(NUM_PORTS))) port_d = csr_wdata[PORT_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (wr_cmd) begin
          case (csr_wdata[1:0])
            2'b01, 2'b10: begin
              tc_rd_d       = csr_wdata[0];
              tc_wr_d       = csr_wdata[1];
              tc_addr_d     = csr_wdata[47:32];
              tc_port_d     = port_q;
              tc_wdata_d    = wr_data_q;
              ack_trans_d   = 1'b0;
              timeout_err_d = 1'b0;
              cnt_d         = '0;
              state_d       = ST_REQ;
            end
            2'b11: begin
              ack_trans_d   = 1'b1;
              timeout_err_d = 1'b1;
            end
            default: begin
              ack_trans_d   = 1'b0;
              timeout_err_d = 1'b0;
            end
          endcase
        end
      end
      ST_REQ: begin
        // An ack on the final counted cycle still wins over the timeout
        if (tc_ack) begin
          if (tc_rd_q) rd_data_d = tc_rdata;
          tc_rd_d = 1'b0;
          tc_wr_d = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          if (tc_rd_q) rd_data_d = 32'hFFFF_FFFF;
          tc_rd_d       = 1'b0;
          tc_wr_d       = 1'b0;
          timeout_err_d = 1'b1;
          ack_trans_d   = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        ack_trans_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        tc_rd_d = 1'b0;
        tc_wr_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tc_rd_q       <= 1'b0;
      tc_wr_q       <= 1'b0;
      tc_addr_q     <= '0;
      tc_wdata_q    <= '0;
      tc_port_q     <= '0;
      rd_data_q     <= '0;
      wr_data_q     <= '0;
      port_q        <= '0;
      scratch_q     <= '0;
      swap_q        <= 1'b0;
      init_start_q  <= 1'b0;
      ack_trans_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      link_q        <= '0;
      sticky_q      <= '0;
      csr_rdata_q   <= '0;
      csr_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tc_rd_q       <= tc_rd_d;
      tc_wr_q       <= tc_wr_d;
      tc_addr_q     <= tc_addr_d;
      tc_wdata_q    <= tc_wdata_d;
      tc_port_q     <= tc_port_d;
      rd_data_q     <= rd_data_d;
      wr_data_q     <= wr_data_d;
      port_q        <= port_d;
      scratch_q     <= scratch_d;
      swap_q        <= swap_d;
      init_start_q  <= init_start_d;
      ack_trans_q   <= ack_trans_d;
      timeout_err_q <= timeout_err_d;
      link_q        <= link_d;
      sticky_q      <= sticky_d;
      csr_rdata_q   <= csr_rdata_d;
      csr_rvalid_q  <= csr_rvalid_d;
    end
  end

  assign csr_rdata  = csr_rdata_q;
  assign csr_rvalid = csr_rvalid_q;
  assign tc_rd      = tc_rd_q;
  assign tc_wr      = tc_wr_q;
  assign tc_addr    = tc_addr_q;
  assign tc_wdata   = tc_wdata_q;
  assign tc_port    = tc_port_q;
  assign init_start = init_start_q;
  assign swap_en    = swap_q;

endmodule

// File: tb/tb_eth_traffic_csr_mp.sv
// Randomized bench for eth_traffic_csr_mp against a register-level reference model.
module tb_eth_traffic_csr_mp;

  localparam int unsigned NP = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned TO = 16;
  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  localparam logic [23:0] NDFH = 24'h00_1000;

  localparam logic [15:0] A_DFH = 16'h0000, A_IDL = 16'h0008, A_IDH = 16'h0010;
  localparam logic [15:0] A_INIT = 16'h0028, A_CMD = 16'h0030, A_DATA = 16'h0038;
  localparam logic [15:0] A_PORT = 16'h0040, A_SCR = 16'h0048, A_SWAP = 16'h0050;
  localparam logic [15:0] A_LINK = 16'h0058;

  logic          clk, rst_n;
  logic          csr_wr, csr_rd;
  logic [15:0]   csr_addr;
  logic [63:0]   csr_wdata, csr_rdata;
  logic          csr_rvalid;
  logic          tc_rd, tc_wr, tc_ack;
  logic [15:0]   tc_addr;
  logic [31:0]   tc_wdata, tc_rdata;
  logic [PW-1:0] tc_port;
  logic          init_start, init_done, swap_en;
  logic [NP-1:0] link_up;

  eth_traffic_csr_mp #(
    .NUM_PORTS(NP), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H),
    .NEXT_DFH(NDFH), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .tc_rd(tc_rd), .tc_wr(tc_wr), .tc_addr(tc_addr), .tc_wdata(tc_wdata), .tc_port(tc_port),
    .tc_ack(tc_ack), .tc_rdata(tc_rdata),
    .init_start(init_start), .init_done(init_done), .swap_en(swap_en), .link_up(link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [63:0]   m_scratch;
  logic          m_swap;
  logic [PW-1:0] m_port;
  logic [31:0]   m_wrdata, m_rddata;
  logic [15:0]   m_addr;
  logic          m_te, m_at;
  logic [NP-1:0] m_link, m_sticky;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_scratch = '0; m_swap = 1'b0; m_port = '0; m_wrdata = '0; m_rddata = '0;
    m_addr = '0; m_te = 1'b0; m_at = 1'b0; m_link = '0; m_sticky = '0;
  endtask

  function automatic logic [63:0] exp_read(input logic [15:0] a);
    case (a)
      A_DFH:  return {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, NDFH, 4'h1, 12'h0};
      A_IDL:  return ID_L;
      A_IDH:  return ID_H;
      A_INIT: return {62'h0, init_done, 1'b0};
      A_CMD:  return {16'h0, m_addr, 27'h0, m_te, 1'b0, m_at, 2'b00};
      A_DATA: return {m_wrdata, m_rddata};
      A_PORT: return 64'(m_port);
      A_SCR:  return m_scratch;
      A_SWAP: return {63'h0, m_swap};
      A_LINK: return {28'h0, m_sticky, 28'h0, m_link};
      default: return 64'h0;
    endcase
  endfunction

  task automatic csr_write(input logic [15:0] a, input logic [63:0] d);
    csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [15:0] a, output logic [63:0] d);
    csr_rd = 1'b1; csr_addr = a;
    tick();
    check_eq("rvalid", 64'(csr_rvalid), 64'd1);
    d = csr_rdata;
    csr_rd = 1'b0;
  endtask

  task automatic rd_chk(input logic [15:0] a, input string tag);
    logic [63:0] v;
    csr_read(a, v);
    check_eq(tag, v, exp_read(a));
  endtask

  // Non-command register write, model updated from the register rules
  task automatic wr_reg(input logic [15:0] a, input logic [63:0] d);
    csr_write(a, d);
    case (a)
      A_SCR:  m_scratch = d;
      A_SWAP: m_swap = d[0];
      A_PORT: if (d < 64'(NP)) m_port = d[PW-1:0];
      A_DATA: m_wrdata = d[63:32];
      A_LINK: m_sticky = m_sticky & ~d[32 +: NP];
      default: ;
    endcase
    if (a == A_INIT) check_eq("init_pulse", 64'(init_start), 64'(d[0]));
    if (a == A_SWAP) check_eq("swap_en", 64'(swap_en), 64'(m_swap));
  endtask

  task automatic set_link(input logic [NP-1:0] v);
    link_up = v;
    tick();
    tick();
    m_sticky = m_sticky | (m_link & ~v);
    m_link = v;
  endtask

  // Issue a CMD and play the traffic controller: ack after d request cycles
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] a, input int d, input logic [31:0] rdat);
    bit ok;
    int n;
    csr_write(A_CMD, {16'h0, a, 30'h0, op});
    if (op == 2'b01 || op == 2'b10) begin
      ok = 1'b1;
      n = (d < int'(TO)) ? d : int'(TO);
      for (int i = 0; i < n; i++) begin
        if (tc_rd !== op[0] || tc_wr !== op[1] || tc_addr !== a || tc_port !== m_port ||
            (op[1] && tc_wdata !== m_wrdata)) ok = 1'b0;
        tick();
      end
      if (d < int'(TO)) begin
        check_eq("req_before_ack", {62'h0, tc_wr, tc_rd}, {62'h0, op});
        tc_ack = 1'b1; tc_rdata = rdat;
        tick();
        tc_ack = 1'b0; tc_rdata = $urandom;
        check_eq("req_drop_ack", {62'h0, tc_wr, tc_rd}, 64'h0);
        tick();
        if (op[0]) m_rddata = rdat;
        m_te = 1'b0;
      end else begin
        check_eq("req_drop_timeout", {62'h0, tc_wr, tc_rd}, 64'h0);
        tc_ack = 1'b1;
        tick();
        tc_ack = 1'b0;
        check_eq("stray_ack", {62'h0, tc_wr, tc_rd}, 64'h0);
        if (op[0]) m_rddata = 32'hFFFF_FFFF;
        m_te = 1'b1;
      end
      check_eq("req_hold", 64'(ok), 64'd1);
      m_at = 1'b1;
      m_addr = a;
    end else if (op == 2'b11) begin
      check_eq("no_req_both", {62'h0, tc_wr, tc_rd}, 64'h0);
      tick();
      check_eq("no_req_both2", {62'h0, tc_wr, tc_rd}, 64'h0);
      m_te = 1'b1; m_at = 1'b1;
    end else begin
      m_te = 1'b0; m_at = 1'b0;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: sim time got %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] addrs [12];
    logic [63:0] v, d;
    logic [15:0] a;
    int sel;

    addrs = '{A_DFH, A_IDL, A_IDH, A_INIT, A_CMD, A_DATA, A_PORT, A_SCR, A_SWAP, A_LINK,
              16'h0060, 16'h0018};
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; csr_wr = 1'b0; csr_rd = 1'b0; csr_addr = '0; csr_wdata = '0;
    tc_ack = 1'b0; tc_rdata = '0; init_done = 1'b0; link_up = '0;
    model_reset();
    #23;
    check_eq("rst_outs", {56'h0, tc_rd, tc_wr, init_start, swap_en, csr_rvalid, 3'b0}, 64'h0);
    check_eq("rst_rdata", csr_rdata, 64'h0);
    rst_n = 1'b1;
    tick();

    foreach (addrs[i]) rd_chk(addrs[i], "reset_read");
    tick();
    check_eq("rvalid_drop", 64'(csr_rvalid), 64'd0);

    // Same-cycle read and write returns the pre-write value
    csr_rd = 1'b1; csr_wr = 1'b1; csr_addr = A_SCR; csr_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    csr_rd = 1'b0; csr_wr = 1'b0;
    check_eq("rw_same_cycle", csr_rdata, 64'h0);
    m_scratch = 64'hDEAD_BEEF_0BAD_F00D;
    rd_chk(A_SCR, "scratch_after_rw");

    wr_reg(A_INIT, 64'h1);
    tick();
    check_eq("init_pulse_end", 64'(init_start), 64'd0);
    init_done = 1'b1;
    rd_chk(A_INIT, "init_done_rd");

    // Indirect write to port 3
    wr_reg(A_PORT, 64'd3);
    wr_reg(A_DATA, {32'hA5A5_0001, 32'h0});
    do_cmd(2'b10, 16'h0010, 4, 32'h0);
    csr_read(A_CMD, v);
    check_eq("cmd_after_wr", v, {16'h0, 16'h0010, 27'h0, 1'b0, 1'b0, 1'b1, 2'b00});

    // Indirect read completes after 5 cycles
    do_cmd(2'b01, 16'h0020, 5, 32'h1234_5678);
    csr_read(A_DATA, v);
    check_eq("data_rd_ack", {32'h0, v[31:0]}, 64'h1234_5678);
    rd_chk(A_CMD, "cmd_rd_ack");

    // Indirect read with no ack times out
    do_cmd(2'b01, 16'h0030, 40, 32'h0);
    csr_read(A_DATA, v);
    check_eq("data_timeout", {32'h0, v[31:0]}, 64'hFFFF_FFFF);
    csr_read(A_CMD, v);
    check_eq("cmd_timeout", {59'h0, v[4], 1'b0, v[2], 2'b0}, 64'h14);

    // Ack on the last counted cycle is a success
    do_cmd(2'b01, 16'h0044, int'(TO) - 1, 32'hCAFE_0001);
    rd_chk(A_DATA, "ack_last_cycle");
    rd_chk(A_CMD, "cmd_last_cycle");

    // Out-of-range port and rd+wr together
    wr_reg(A_PORT, 64'd5);
    csr_read(A_PORT, v);
    check_eq("port_oor", v, 64'd3);
    do_cmd(2'b11, 16'h0050, 0, 32'h0);
    rd_chk(A_CMD, "cmd_both");
    do_cmd(2'b00, 16'h0051, 0, 32'h0);
    rd_chk(A_CMD, "cmd_neither");

    // Writes while busy: registers update, in-flight request untouched
    wr_reg(A_PORT, 64'd1);
    wr_reg(A_DATA, {32'h1111_0000, 32'h0});
    csr_write(A_CMD, {16'h0, 16'h0055, 30'h0, 2'b10});
    wr_reg(A_PORT, 64'd2);
    wr_reg(A_DATA, {32'h2222_0000, 32'h0});
    csr_write(A_CMD, {16'h0, 16'h0077, 30'h0, 2'b01});
    check_eq("busy_req", {tc_wr, tc_rd, 14'h0, tc_addr, tc_wdata}, {2'b10, 14'h0, 16'h0055, 32'h1111_0000});
    check_eq("busy_port", 64'(tc_port), 64'd1);
    tc_ack = 1'b1;
    tick();
    tc_ack = 1'b0;
    tick();
    m_addr = 16'h0055; m_at = 1'b1; m_te = 1'b0;
    rd_chk(A_PORT, "busy_port_reg");
    rd_chk(A_DATA, "busy_data_reg");
    rd_chk(A_CMD, "busy_cmd_reg");

    // Link status and sticky link-down flags
    set_link(4'hF);
    set_link(4'hB);
    csr_read(A_LINK, v);
    check_eq("link_drop", {59'h0, v[34], v[3:0]}, 64'h1B);
    wr_reg(A_LINK, 64'h4 << 32);
    rd_chk(A_LINK, "link_w1c");
    set_link(4'hF);
    set_link(4'hB);
    set_link(4'hF);
    link_up = 4'hB;
    wr_reg(A_LINK, 64'h4 << 32);
    m_sticky = m_sticky | (m_link & ~4'hB);
    m_link = 4'hB;
    tick();
    csr_read(A_LINK, v);
    check_eq("link_set_wins", 64'(v[34]), 64'd1);
    rd_chk(A_LINK, "link_set_wins_all");

    // Randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: begin
          a = addrs[$urandom_range(0, 11)];
          if (a == A_CMD) a = A_SCR;
          d = {$urandom, $urandom};
          if (a == A_PORT) d = 64'($urandom_range(0, 7));
          wr_reg(a, d);
        end
        1: rd_chk(addrs[$urandom_range(0, 11)], "rand_read");
        2, 3: begin
          do_cmd(2'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 20)), $urandom);
          rd_chk(A_CMD, "rand_cmd");
          rd_chk(A_DATA, "rand_data");
        end
        4: set_link(NP'($urandom));
        default: begin
          init_done = 1'($urandom);
          rd_chk(A_INIT, "rand_init");
        end
      endcase
    end

    // Reset in the middle of a request
    link_up = 4'hF;
    tick();
    csr_write(A_CMD, {16'h0, 16'h00AA, 30'h0, 2'b01});
    tick();
    check_eq("req_pre_reset", {62'h0, tc_wr, tc_rd}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_req", {62'h0, tc_wr, tc_rd}, 64'h0);
    check_eq("rst_async_misc", {61'h0, init_start, swap_en, csr_rvalid}, 64'h0);
    tick();
    #2 rst_n = 1'b1;
    tc_ack = 1'b1; tc_rdata = 32'h5555_AAAA;
    tick();
    tc_ack = 1'b0;
    check_eq("ack_after_rst", {62'h0, tc_wr, tc_rd}, 64'h0);
    model_reset();
    m_link = 4'hF;
    foreach (addrs[i]) rd_chk(addrs[i], "post_reset_read");
    csr_read(A_DFH, v);
    check_eq("dfh_eol", 64'(v[40]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
